// File: rtl/siso_frame_buffer_if.sv
// siso_frame_buffer_if
// Bundles the write handshake, replay handshake and status signals of the
// SISO ping-pong frame buffer.
//   slave  : the buffer itself (takes write triplets and replay requests,
//            drives replay beats and bank status)
//   master : the producer/consumer side (testbench or surrounding datapath)
// Write side  : wr_valid_i, wr_ready_o, sys_i, enc_i, ext_i
// Replay side : rd_start_i, rd_mode_i, rd_valid_o, rd_ready_i,
//               sys_o, enc_o, ext_o, rd_idx_o, rd_last_o
// Status      : frame_done_o, bank_full_o
interface siso_frame_buffer_if #(
  parameter int SYS_W     = 7,
  parameter int PAR_W     = 7,
  parameter int EXT_W     = 10,
  parameter int FRAME_LEN = 16
);
  localparam int IDX_W = $clog2(FRAME_LEN);

  logic             wr_valid_i;
  logic             wr_ready_o;
  logic [SYS_W-1:0] sys_i;
  logic [PAR_W-1:0] enc_i;
  logic [EXT_W-1:0] ext_i;

  logic             rd_start_i;
  logic [1:0]       rd_mode_i;
  logic             rd_valid_o;
  logic             rd_ready_i;
  logic [SYS_W-1:0] sys_o;
  logic [PAR_W-1:0] enc_o;
  logic [EXT_W-1:0] ext_o;
  logic [IDX_W-1:0] rd_idx_o;
  logic             rd_last_o;

  logic             frame_done_o;
  logic [1:0]       bank_full_o;

  modport slave (
    input  wr_valid_i, sys_i, enc_i, ext_i,
    input  rd_start_i, rd_mode_i, rd_ready_i,
    output wr_ready_o,
    output rd_valid_o, sys_o, enc_o, ext_o, rd_idx_o, rd_last_o,
    output frame_done_o, bank_full_o
  );

  modport master (
    output wr_valid_i, sys_i, enc_i, ext_i,
    output rd_start_i, rd_mode_i, rd_ready_i,
    input  wr_ready_o,
    input  rd_valid_o, sys_o, enc_o, ext_o, rd_idx_o, rd_last_o,
    input  frame_done_o, bank_full_o
  );
endinterface

// File: rtl/siso_frame_buffer.sv
// siso_frame_buffer
// Ping-pong input buffer in front of the SISO decoder core. One bank captures
// a frame of (systematic, parity, extrinsic) triplets while the other bank is
// replayed forward, reverse, or forward-then-reverse for the alpha/beta
// recursions.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : siso_frame_buffer_if.slave (write handshake, replay handshake,
//            frame_done_o pulse, bank_full_o flags)
module siso_frame_buffer #(
  parameter int SYS_W     = 7,
  parameter int PAR_W     = 7,
  parameter int EXT_W     = 10,
  parameter int FRAME_LEN = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  siso_frame_buffer_if.slave   bus
);
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, FWD, REV, DRAIN} state_t;

  // Storage, indexed [bank][address]; never reset
  logic [SYS_W-1:0] sys_mem [0:1][0:FRAME_LEN-1];
  logic [PAR_W-1:0] enc_mem [0:1][0:FRAME_LEN-1];
  logic [EXT_W-1:0] ext_mem [0:1][0:FRAME_LEN-1];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] raddr_q, raddr_d;
  logic             dual_q, dual_d;
  logic [IDX_W-1:0] wptr_q;
  logic             wr_bank_q, rd_bank_q;
  logic [1:0]       bank_full_q, bank_full_d;

  logic             rd_valid_q, rd_last_q, frame_done_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [SYS_W-1:0] sys_q;
  logic [PAR_W-1:0] enc_q;
  logic [EXT_W-1:0] ext_q;

  logic wr_ready, wr_fire, wr_wrap;
  logic advance, issue, issue_last, complete;

  assign wr_ready = !bank_full_q[wr_bank_q];
  assign wr_fire  = bus.wr_valid_i && wr_ready;
  assign wr_wrap  = wr_fire && (wptr_q == LAST_ADDR);

  // Output register may load a new beat when empty or when its beat is taken
  assign advance  = !rd_valid_q || bus.rd_ready_i;

  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      sys_mem[wr_bank_q][wptr_q] <= bus.sys_i;
      enc_mem[wr_bank_q][wptr_q] <= bus.enc_i;
      ext_mem[wr_bank_q][wptr_q] <= bus.ext_i;
    end
  end

  // Replay sequencing. raddr is the address of the next beat to issue. In
  // forward-then-reverse mode the address is held at the turnaround so the
  // final forward address is issued again as the first reverse beat. DRAIN
  // waits for the consumer to take the final beat before releasing the bank.
  // A request is not taken during the frame_done_o cycle.
  always_comb begin
    state_d    = state_q;
    raddr_d    = raddr_q;
    dual_d     = dual_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    complete   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.rd_start_i && bank_full_q[rd_bank_q] && !frame_done_q) begin
          dual_d = (bus.rd_mode_i == 2'b10);
          if (bus.rd_mode_i == 2'b01) begin
            state_d = REV;
            raddr_d = LAST_ADDR;
          end else begin
            state_d = FWD;
            raddr_d = '0;
          end
        end
      end
      FWD: begin
        if (advance) begin
          issue      = 1'b1;
          issue_last = (raddr_q == LAST_ADDR);
          if (raddr_q == LAST_ADDR) begin
            state_d = dual_q ? REV : DRAIN;
          end else begin
            raddr_d = raddr_q + IDX_W'(1);
          end
        end
      end
      REV: begin
        if (advance) begin
          issue      = 1'b1;
          issue_last = (raddr_q == '0);
          if (raddr_q == '0) begin
            state_d = DRAIN;
          end else begin
            raddr_d = raddr_q - IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (bus.rd_ready_i) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Writer only fills an empty bank and reader only drains a full one, so
  // the set and clear below never target the same bank.
  always_comb begin
    bank_full_d = bank_full_q;
    if (wr_wrap) begin
      bank_full_d[wr_bank_q] = 1'b1;
    end
    if (complete) begin
      bank_full_d[rd_bank_q] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      raddr_q     <= '0;
      dual_q      <= 1'b0;
      wptr_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      dual_q      <= dual_d;
      bank_full_q <= bank_full_d;
      if (wr_fire) begin
        wptr_q <= wr_wrap ? '0 : wptr_q + IDX_W'(1);
      end
      if (wr_wrap) begin
        wr_bank_q <= !wr_bank_q;
      end
      if (complete) begin
        rd_bank_q <= !rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      frame_done_q <= 1'b0;
      rd_idx_q     <= '0;
      sys_q        <= '0;
      enc_q        <= '0;
      ext_q        <= '0;
    end else begin
      frame_done_q <= complete;
      if (issue) begin
        rd_valid_q <= 1'b1;
        rd_last_q  <= issue_last;
        rd_idx_q   <= raddr_q;
        sys_q      <= sys_mem[rd_bank_q][raddr_q];
        enc_q      <= enc_mem[rd_bank_q][raddr_q];
        ext_q      <= ext_mem[rd_bank_q][raddr_q];
      end else if (complete) begin
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
      end
    end
  end

  assign bus.wr_ready_o   = wr_ready;
  assign bus.rd_valid_o   = rd_valid_q;
  assign bus.rd_last_o    = rd_last_q;
  assign bus.rd_idx_o     = rd_idx_q;
  assign bus.sys_o        = sys_q;
  assign bus.enc_o        = enc_q;
  assign bus.ext_o        = ext_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.bank_full_o  = bank_full_q;
endmodule
